tx_ipv4_checksum_insert: RTL and testbench

//  Fills the checksum stage between tx_headers_prepend and the CMAC TX port in ethernet_tx.

---
 rtl/tx_ipv4_checksum_insert.sv | 184 ++++++++++++++++++
 tb/tb_tx_ipv4_checksum_insert.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_ipv4_checksum_insert.sv
// IPv4 header checksum insertion on the first beat of each TX frame, with optional
// UDP checksum zeroing. Two registered stages (S1 capture + partial sum, S2 fold + patch).
module tx_ipv4_checksum_insert #(
  parameter int DATA_WIDTH    = 512,
  parameter int UDP_CSUM_ZERO = 1,
  parameter int STAT_WIDTH    = 32
) (
  input  logic                      tx_axis_aclk,
  input  logic                      tx_axis_areset,
  input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0]   s_axis_tkeep,
  input  logic                      s_axis_tvalid,
  input  logic                      s_axis_tlast,
  output logic                      s_axis_tready,
  output logic [DATA_WIDTH-1:0]     m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]   m_axis_tkeep,
  output logic                      m_axis_tvalid,
  output logic                      m_axis_tlast,
  input  logic                      m_axis_tready,
  output logic [STAT_WIDTH-1:0]     stat_csum_frames,
  output logic [STAT_WIDTH-1:0]     stat_bypass_frames
);

  localparam int KEEP_W = DATA_WIDTH / 8;

  function automatic logic [7:0] byte_at(input logic [DATA_WIDTH-1:0] d, input int k);
    return d[8*k +: 8];
  endfunction

  // Sum of the ten header words with the checksum field (word 5) treated as zero.
  function automatic logic [19:0] hdr_sum(input logic [DATA_WIDTH-1:0] d);
    logic [19:0] acc;
    acc = '0;
    for (int i = 0; i < 10; i++) begin
      if (i != 5) acc = acc + {4'h0, d[8*(14+2*i) +: 8], d[8*(15+2*i) +: 8]};
    end
    return acc;
  endfunction

  function automatic logic [15:0] fold_csum(input logic [19:0] s);
    logic [16:0] t1;
    logic [16:0] t2;
    t1 = {1'b0, s[15:0]} + {13'h0, s[19:16]};
    t2 = {1'b0, t1[15:0]} + {16'h0, t1[16]};
    return ~t2[15:0];
  endfunction

  logic                  sof_q, sof_d;

  logic                  vld_p1_q, vld_p1_d;
  logic [DATA_WIDTH-1:0] data_p1_q, data_p1_d;
  logic [KEEP_W-1:0]     keep_p1_q, keep_p1_d;
  logic                  last_p1_q, last_p1_d;
  logic                  sof_p1_q, sof_p1_d;
  logic                  elig_p1_q, elig_p1_d;
  logic                  udp_p1_q, udp_p1_d;
  logic [19:0]           sum_p1_q, sum_p1_d;

  logic                  vld_p2_q, vld_p2_d;
  logic [DATA_WIDTH-1:0] data_p2_q, data_p2_d;
  logic [KEEP_W-1:0]     keep_p2_q, keep_p2_d;
  logic                  last_p2_q, last_p2_d;
  logic                  sof_p2_q, sof_p2_d;
  logic                  elig_p2_q, elig_p2_d;

  logic [STAT_WIDTH-1:0] csum_cnt_q, csum_cnt_d;
  logic [STAT_WIDTH-1:0] byp_cnt_q, byp_cnt_d;

  logic                  en;
  logic                  s_rdy;
  logic                  accept;
  logic                  hdr_ok;
  logic [15:0]           csum;
  logic [DATA_WIDTH-1:0] patched;

  always_comb begin
    en     = !vld_p2_q || m_axis_tready;
    s_rdy  = !vld_p1_q || en;
    accept = s_axis_tvalid && s_rdy;
    hdr_ok = (&s_axis_tkeep[33:0]) &&
             (byte_at(s_axis_tdata, 12) == 8'h08) &&
             (byte_at(s_axis_tdata, 13) == 8'h00) &&
             (byte_at(s_axis_tdata, 14) == 8'h45);

    sof_d = sof_q;
    if (accept) sof_d = s_axis_tlast;

    // S1: capture beat, header eligibility and the unfolded word sum
    vld_p1_d  = vld_p1_q;
    data_p1_d = data_p1_q;
    keep_p1_d = keep_p1_q;
    last_p1_d = last_p1_q;
    sof_p1_d  = sof_p1_q;
    elig_p1_d = elig_p1_q;
    udp_p1_d  = udp_p1_q;
    sum_p1_d  = sum_p1_q;
    if (s_rdy) begin
      vld_p1_d  = s_axis_tvalid;
      data_p1_d = s_axis_tdata;
      keep_p1_d = s_axis_tkeep;
      last_p1_d = s_axis_tlast;
      sof_p1_d  = sof_q;
      elig_p1_d = s_axis_tvalid && sof_q && hdr_ok;
      udp_p1_d  = (UDP_CSUM_ZERO != 0) && s_axis_tvalid && sof_q && hdr_ok &&
                  (byte_at(s_axis_tdata, 23) == 8'h11) && (s_axis_tkeep[41:40] == 2'b11);
      sum_p1_d  = hdr_sum(s_axis_tdata);
    end

    // S2: fold the sum and patch the header fields into the output beat
    csum    = fold_csum(sum_p1_q);
    patched = data_p1_q;
    if (elig_p1_q) begin
      patched[8*24 +: 8] = csum[15:8];
      patched[8*25 +: 8] = csum[7:0];
    end
    if (udp_p1_q) patched[8*40 +: 16] = 16'h0000;

    vld_p2_d  = vld_p2_q;
    data_p2_d = data_p2_q;
    keep_p2_d = keep_p2_q;
    last_p2_d = last_p2_q;
    sof_p2_d  = sof_p2_q;
    elig_p2_d = elig_p2_q;
    if (en) begin
      vld_p2_d  = vld_p1_q;
      data_p2_d = patched;
      keep_p2_d = keep_p1_q;
      last_p2_d = last_p1_q;
      sof_p2_d  = sof_p1_q;
      elig_p2_d = elig_p1_q;
    end

    csum_cnt_d = csum_cnt_q;
    byp_cnt_d  = byp_cnt_q;
    if (vld_p2_q && m_axis_tready && sof_p2_q) begin
      if (elig_p2_q) csum_cnt_d = csum_cnt_q + 1'b1;
      else           byp_cnt_d  = byp_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge tx_axis_aclk) begin
    if (tx_axis_areset) begin
      sof_q      <= 1'b1;
      vld_p1_q   <= 1'b0;
      vld_p2_q   <= 1'b0;
      data_p2_q  <= '0;
      keep_p2_q  <= '0;
      last_p2_q  <= 1'b0;
      csum_cnt_q <= '0;
      byp_cnt_q  <= '0;
    end else begin
      sof_q      <= sof_d;
      vld_p1_q   <= vld_p1_d;
      vld_p2_q   <= vld_p2_d;
      data_p2_q  <= data_p2_d;
      keep_p2_q  <= keep_p2_d;
      last_p2_q  <= last_p2_d;
      csum_cnt_q <= csum_cnt_d;
      byp_cnt_q  <= byp_cnt_d;
    end
  end

  // Payload and side-band flags are qualified by the valid bits, so they carry no reset.
  always_ff @(posedge tx_axis_aclk) begin
    data_p1_q <= data_p1_d;
    keep_p1_q <= keep_p1_d;
    last_p1_q <= last_p1_d;
    sof_p1_q  <= sof_p1_d;
    elig_p1_q <= elig_p1_d;
    udp_p1_q  <= udp_p1_d;
    sum_p1_q  <= sum_p1_d;
    sof_p2_q  <= sof_p2_d;
    elig_p2_q <= elig_p2_d;
  end

  assign s_axis_tready      = s_rdy;
  assign m_axis_tdata       = data_p2_q;
  assign m_axis_tkeep       = keep_p2_q;
  assign m_axis_tvalid      = vld_p2_q;
  assign m_axis_tlast       = last_p2_q;
  assign stat_csum_frames   = csum_cnt_q;
  assign stat_bypass_frames = byp_cnt_q;

endmodule

// File: tb/tb_tx_ipv4_checksum_insert.sv
// Directed bench for tx_ipv4_checksum_insert with a frame-level reference model and scoreboard.
module tb_tx_ipv4_checksum_insert;
  localparam int DW   = 512;
  localparam int KW   = DW / 8;
  localparam int SW   = 32;
  localparam int UDPZ = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] s_tdata = '0;
  logic [KW-1:0] s_tkeep = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tlast = 1'b0;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_tvalid;
  logic          m_tlast;
  logic          m_tready = 1'b1;
  logic [SW-1:0] st_csum, st_byp;

  tx_ipv4_checksum_insert #(.DATA_WIDTH(DW), .UDP_CSUM_ZERO(UDPZ), .STAT_WIDTH(SW)) dut (
    .tx_axis_aclk(clk), .tx_axis_areset(rst),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
    .stat_csum_frames(st_csum), .stat_bypass_frames(st_byp)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
    logic          f;
    logic          e;
  } beat_t;

  int    total = 0;
  int    bad = 0;
  beat_t exp_q[$];
  beat_t out_log[$];
  bit    mdl_sof = 1'b1;
  int    held = 0;
  logic [SW-1:0] mc_csum = '0;
  logic [SW-1:0] mc_byp = '0;
  bit    rand_rdy = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic chk_d(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [7:0] gb(input logic [DW-1:0] d, input int n);
    return d[8*n +: 8];
  endfunction

  function automatic logic [DW-1:0] put(input logic [DW-1:0] d, input int n, input logic [7:0] v);
    logic [DW-1:0] r;
    r = d;
    r[8*n +: 8] = v;
    return r;
  endfunction

  // Reference: one's-complement sum with end-around carry applied after every word.
  function automatic beat_t model_out(input logic [DW-1:0] d, input logic [KW-1:0] k,
                                      input logic l, input logic first);
    beat_t       b;
    logic [16:0] s;
    logic [15:0] w;
    logic [15:0] c;
    b.d = d; b.k = k; b.l = l; b.f = first;
    b.e = first && (&k[33:0]) && gb(d, 12) == 8'h08 && gb(d, 13) == 8'h00 && gb(d, 14) == 8'h45;
    if (b.e) begin
      s = '0;
      for (int i = 0; i < 10; i++) begin
        if (i != 5) begin
          w = {gb(d, 14 + 2*i), gb(d, 15 + 2*i)};
          s = s + {1'b0, w};
          if (s[16]) s = {1'b0, s[15:0]} + 17'd1;
        end
      end
      c = ~s[15:0];
      b.d[8*24 +: 8] = c[15:8];
      b.d[8*25 +: 8] = c[7:0];
      if (UDPZ != 0 && gb(d, 23) == 8'h11 && k[40] && k[41]) b.d[8*40 +: 16] = 16'h0000;
    end
    return b;
  endfunction

  logic [DW-1:0] pd;
  logic [KW-1:0] pk;
  logic          pl;
  bit            prev_stall = 1'b0;

  always @(negedge clk) begin
    beat_t eb;
    beat_t nb;
    if (prev_stall) begin
      chk("stall_valid", {63'h0, m_tvalid}, 64'h1);
      chk_d("stall_data", m_tdata, pd);
      chk("stall_keep", m_tkeep, pk);
      chk("stall_last", {63'h0, m_tlast}, {63'h0, pl});
    end
    if (rst) begin
      exp_q.delete();
      mdl_sof = 1'b1;
      held = 0;
      mc_csum = '0;
      mc_byp = '0;
      prev_stall = 1'b0;
    end else begin
      chk("stat_csum", st_csum, mc_csum);
      chk("stat_bypass", st_byp, mc_byp);
      if (!s_tready) chk("ready_low_needs_two_held", held, 2);
      if (held > 2) chk("buffer_depth", held, 2);
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 64'h1, 64'h0);
        end else begin
          eb = exp_q.pop_front();
          chk_d("out_data", m_tdata, eb.d);
          chk("out_keep", m_tkeep, eb.k);
          chk("out_last", {63'h0, m_tlast}, {63'h0, eb.l});
          if (eb.f) begin
            if (eb.e) mc_csum = mc_csum + 1;
            else      mc_byp  = mc_byp + 1;
          end
          held--;
        end
        nb.d = m_tdata; nb.k = m_tkeep; nb.l = m_tlast; nb.f = 1'b0; nb.e = 1'b0;
        out_log.push_back(nb);
      end
      if (s_tvalid && s_tready) begin
        exp_q.push_back(model_out(s_tdata, s_tkeep, s_tlast, mdl_sof));
        mdl_sof = s_tlast;
        held++;
      end
      prev_stall = m_tvalid && !m_tready;
      pd = m_tdata; pk = m_tkeep; pl = m_tlast;
    end
  end

  always begin
    @(posedge clk);
    #1;
    m_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic send(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
    int n;
    n = 0;
    s_tdata = d; s_tkeep = k; s_tlast = l; s_tvalid = 1'b1;
    @(negedge clk);
    while (!s_tready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) chk("send_timeout", 64'h1, 64'h0);
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      n++;
      @(posedge clk);
    end
    if (n >= 500) chk("drain_timeout", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] base_beat();
    logic [DW-1:0] d;
    logic [7:0]    hdr [20];
    hdr = '{8'h45, 8'h00, 8'h00, 8'h73, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
            8'h00, 8'h00, 8'hc0, 8'ha8, 8'h00, 8'h01, 8'hc0, 8'ha8, 8'h00, 8'hc7};
    d = '0;
    for (int n = 0; n < KW; n++) d = put(d, n, 8'(n * 3 + 1));
    d = put(d, 12, 8'h08);
    d = put(d, 13, 8'h00);
    for (int n = 0; n < 20; n++) d = put(d, 14 + n, hdr[n]);
    return d;
  endfunction

  initial begin
    logic [DW-1:0] b1, b2, b3, fa, fb;
    logic [KW-1:0] kc;
    logic [SW-1:0] c0, y0;
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] b1, b2, b3, fa, fb;
    logic [KW-1:0] kc;
    logic [SW-1:0] c0, y0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_tvalid", {63'h0, m_tvalid}, 64'h0);
    chk_d("rst_m_tdata", m_tdata, '0);
    chk("rst_m_tkeep", m_tkeep, 64'h0);
    chk("rst_m_tlast", {63'h0, m_tlast}, 64'h0);
    chk("rst_stat_csum", st_csum, 0);
    chk("rst_stat_bypass", st_byp, 0);
    chk("rst_s_tready", {63'h0, s_tready}, 64'h1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // T1: single-beat frame, latency and checksum value
    b1 = base_beat();
    send(b1, '1, 1'b1);
    chk("t1_not_yet_valid", {63'h0, m_tvalid}, 64'h0);
    @(posedge clk);
    #1;
    chk("t1_valid_at_2", {63'h0, m_tvalid}, 64'h1);
    chk("t1_byte24", gb(m_tdata, 24), 8'hB8);
    chk("t1_byte25", gb(m_tdata, 25), 8'h61);
    drain();
    chk("t1_stat_csum", st_csum, 1);

    // T2: stale checksum overwritten, UDP checksum cleared, later beats untouched
    out_log.delete();
    b1 = put(put(base_beat(), 24, 8'hAA), 25, 8'hBB);
    b1 = put(put(b1, 40, 8'h12), 41, 8'h34);
    b2 = {16{32'hDEAD_0001}};
    b3 = {16{32'h0BAD_F00D}};
    send(b1, '1, 1'b0);
    send(b2, '1, 1'b0);
    send(b3, 64'h0000_0000_0000_FFFF, 1'b1);
    drain();
    chk("t2_out_beats", out_log.size(), 3);
    if (out_log.size() == 3) begin
      chk("t2_b24_25", {gb(out_log[0].d, 24), gb(out_log[0].d, 25)}, 16'hB861);
      chk("t2_b40_41", {gb(out_log[0].d, 40), gb(out_log[0].d, 41)}, 16'h0000);
      chk_d("t2_beat2_exact", out_log[1].d, b2);
      chk_d("t2_beat3_exact", out_log[2].d, b3);
    end

    // T3: three non-eligible first beats pass bit-exact
    out_log.delete();
    c0 = st_csum; y0 = st_byp;
    fa = put(put(base_beat(), 12, 8'h86), 13, 8'hDD);
    fb = put(base_beat(), 14, 8'h46);
    kc = 64'h0000_0000_7FFF_FFFF;
    send(fa, '1, 1'b1);
    send(fb, '1, 1'b1);
    send(base_beat(), kc, 1'b1);
    drain();
    chk("t3_bypass_delta", st_byp - y0, 3);
    chk("t3_csum_delta", st_csum - c0, 0);
    if (out_log.size() == 3) begin
      chk_d("t3_ethertype_exact", out_log[0].d, fa);
      chk_d("t3_ihl_exact", out_log[1].d, fb);
      chk_d("t3_keep_exact", out_log[2].d, base_beat());
      chk("t3_keep_out", out_log[2].k, kc);
    end else chk("t3_out_beats", out_log.size(), 3);

    // T4: full-rate single-beat frames with random backpressure
    out_log.delete();
    c0 = st_csum; y0 = st_byp;
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      b1 = put(base_beat(), 17, 8'(i));
      if (i % 5 == 0) b1 = put(b1, 12, 8'h86);
      send(b1, '1, 1'b1);
    end
    drain();
    rand_rdy = 1'b0;
    chk("t4_out_beats", out_log.size(), 40);
    chk("t4_csum_delta", st_csum - c0, 32);
    chk("t4_bypass_delta", st_byp - y0, 8);
    if (out_log.size() == 40)
      for (int i = 0; i < 40; i += 13) chk("t4_order", gb(out_log[i].d, 17), 8'(i));

    // T5: reset while beat 2 of a 4-beat frame is presented
    @(posedge clk);
    #1;
    send(base_beat(), '1, 1'b0);
    s_tdata = {16{32'h5555_AAAA}}; s_tkeep = '1; s_tlast = 1'b0; s_tvalid = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_valid_after_rst", {63'h0, m_tvalid}, 64'h0);
    chk("t5_csum_cnt_rst", st_csum, 0);
    chk("t5_bypass_cnt_rst", st_byp, 0);
    s_tvalid = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    // T6 (also the post-reset frame): carries through the fold
    out_log.delete();
    b1 = base_beat();
    for (int n = 14; n < 34; n++) b1 = put(b1, n, 8'hFF);
    b1 = put(put(b1, 14, 8'h45), 24, 8'h00);
    b1 = put(b1, 25, 8'h00);
    b2 = put(put(b1, 16, 8'hBA), 17, 8'h07);
    send(b2, '1, 1'b1);
    send(b1, '1, 1'b1);
    drain();
    chk("t5_stat_after", st_csum, 2);
    if (out_log.size() == 2) begin
      chk("t6_double_carry", {gb(out_log[0].d, 24), gb(out_log[0].d, 25)}, 16'hFFF8);
      chk("t6_all_ffff", {gb(out_log[1].d, 24), gb(out_log[1].d, 25)}, 16'hBA00);
    end else chk("t6_out_beats", out_log.size(), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
